shift_add_muldiv: RTL and testbench

Parametrised sequential multiply/divide unit for the UART calculator datapath. It is the successor to the fixed 16-bit shift-add multiplier and adds three things: a configurable operand width, signed operation, and restoring division with remainder. It sits behind the parser, is started by the parser's done pulse, and returns one packed result word with an error flag to the result formatter.

---
 rtl/shift_add_muldiv.sv | 138 +++++++++++++
 tb/tb_shift_add_muldiv.sv | 124 ++++++++++++
 2 files changed

// File: rtl/shift_add_muldiv.sv
// shift_add_muldiv: sequential shift-add multiplier / restoring divider, signed or unsigned,
// WIDTH iterations, packed {error, high half, low half} result.
module shift_add_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   src1,
    input  logic [WIDTH-1:0]   src2,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH:0]   calc_res
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     raw_q, raw_d;
    logic                 div_q, div_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic                 dz_q, dz_d;
    logic                 ovf_q, ovf_d;
    logic [2*WIDTH:0]     res_q, res_d;
    logic                 busy_q, done_q;

    logic                 s1n, s2n;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       sum, sh;
    logic [WIDTH-1:0]     rem_w;
    logic                 ge;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod;
    logic [WIDTH-1:0]     quo, rem;

    always_comb begin
        s1n   = op[0] & src1[WIDTH-1];
        s2n   = op[0] & src2[WIDTH-1];
        a_mag = s1n ? -src1 : src1;
        b_mag = s2n ? -src2 : src2;
        // m_q holds the multiplicand for mul and the divisor for div
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
        mul_next = {sum, acc_q[WIDTH-1:1]};
        sh       = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        ge       = sh >= {1'b0, m_q};
        rem_w    = sh[WIDTH-1:0] - m_q;
        div_next = {ge ? rem_w : sh[WIDTH-1:0], acc_q[WIDTH-2:0], ge};
        prod     = qneg_q ? -acc_q : acc_q;
        quo      = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem      = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        raw_d   = raw_q;
        div_d   = div_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        res_d   = res_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = (state_q == DONE) ? IDLE : state_q;
                if (start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    div_d   = op[1];
                    m_d     = op[1] ? b_mag : a_mag;
                    acc_d   = {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
                    raw_d   = src1;
                    qneg_d  = s1n ^ s2n;
                    rneg_d  = s1n;
                    dz_d    = src2 == '0;
                    ovf_d   = op == 2'b11 && src1 == {1'b1, {(WIDTH-1){1'b0}}} && src2 == '1;
                end
            end
            CALC: begin
                acc_d   = div_q ? div_next : mul_next;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH-1)) ? FIX : CALC;
            end
            FIX: begin
                state_d = DONE;
                // overflow needs no override: |min|/1 already wraps back to min with remainder 0
                res_d   = !div_q ? {1'b0, prod} :
                          dz_q   ? {1'b1, raw_q, {WIDTH{1'b1}}} :
                                   {ovf_q, rem, quo};
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            raw_q   <= '0;
            div_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            raw_q   <= raw_d;
            div_q   <= div_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            res_q   <= res_d;
            // status flags trail the state by one edge, giving WIDTH+2 cycle latency
            busy_q  <= state_q == CALC || state_q == FIX;
            done_q  <= state_q == DONE;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign calc_res = res_q;
endmodule

// File: tb/tb_shift_add_muldiv.sv
// tb_shift_add_muldiv: directed checks of shift_add_muldiv at WIDTH=16.
module tb_shift_add_muldiv;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] src1 = '0;
    logic [15:0] src2 = '0;
    logic        busy, done;
    logic [32:0] calc_res;
    int          total = 0;
    int          fails = 0;

    shift_add_muldiv #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
        .busy(busy), .done(done), .calc_res(calc_res)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts an op at edge 0, holds start through edge hold-1, optionally injects one
    // extra start (other operands) at edge inj, and watches edges 1..n.
    task automatic run(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input int hold, input int inj, input int n,
                       output int first, output int second, output int ndone,
                       output logic [32:0] res, output logic busy1, output logic busy_d);
        first = -1; second = -1; ndone = 0; res = 'x; busy1 = 1'bx; busy_d = 1'bx;
        op = o; src1 = a; src2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = (1 < hold) || (1 == inj);
        if (1 == inj) begin op = 2'b00; src1 = 16'h0003; src2 = 16'h0003; end
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            if (k == 1) busy1 = busy;
            if (done) begin
                ndone++;
                if (first < 0) begin first = k; res = calc_res; busy_d = busy; end
                else if (second < 0) second = k;
            end
            start = (k + 1 < hold) || (k + 1 == inj);
            if (k + 1 == inj) begin op = 2'b00; src1 = 16'h0003; src2 = 16'h0003; end
        end
        start = 1'b0;
    endtask

    task automatic one(input string tag, input logic [1:0] o, input logic [15:0] a,
                       input logic [15:0] b, input logic [32:0] exp);
        int f, s, nd;
        logic [32:0] r;
        logic b1, bd;
        run(o, a, b, 1, 0, 24, f, s, nd, r, b1, bd);
        chk({tag, "_lat"}, 64'(f), 64'd18);
        chk({tag, "_res"}, 64'(r), 64'(exp));
        chk({tag, "_busy1"}, 64'(b1), 64'd1);
        chk({tag, "_busydone"}, 64'(bd), 64'd0);
        chk({tag, "_ndone"}, 64'(nd), 64'd1);
    endtask

    initial begin
        int f, s, nd, cnt;
        logic [32:0] r;
        logic b1, bd;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_res", 64'(calc_res), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        one("umul", 2'b00, 16'h0009, 16'h0002, 33'h0_0000_0012);
        one("smul", 2'b01, 16'hFFFD, 16'h0005, 33'h0_FFFF_FFF1);
        one("smul_min", 2'b01, 16'h8000, 16'h8000, 33'h0_4000_0000);
        one("udiv", 2'b10, 16'h0064, 16'h0007, 33'h0_0002_000E);
        one("sdiv", 2'b11, 16'hFFF9, 16'h0002, 33'h0_FFFF_FFFD);
        one("div0", 2'b10, 16'h0005, 16'h0000, 33'h1_0005_FFFF);
        one("sovf", 2'b11, 16'h8000, 16'hFFFF, 33'h1_0000_8000);
        one("umul_max", 2'b00, 16'hFFFF, 16'hFFFF, 33'h0_FFFE_0001);

        run(2'b10, 16'h0064, 16'h0007, 1, 5, 40, f, s, nd, r, b1, bd);
        chk("inj_lat", 64'(f), 64'd18);
        chk("inj_res", 64'(r), 64'h0_0002_000E);
        chk("inj_ndone", 64'(nd), 64'd1);

        run(2'b00, 16'h0009, 16'h0002, 40, 0, 40, f, s, nd, r, b1, bd);
        chk("hold_first", 64'(f), 64'd18);
        chk("hold_second", 64'(s), 64'd36);
        chk("hold_ndone", 64'(nd), 64'd2);
        chk("hold_res", 64'(r), 64'h0_0000_0012);
        repeat (30) @(posedge clk);
        #1;

        op = 2'b01; src1 = 16'h0007; src2 = 16'h0003; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_res", 64'(calc_res), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        chk("abort_nodone", 64'(cnt), 64'd0);

        one("after_rst", 2'b11, 16'h0064, 16'hFFF9, 33'h0_0002_FFF2);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
